mem_access: RTL and testbench



---
 rtl/mem_access_pkg.sv | 29 ++
 rtl/mem_load_fmt.sv | 18 +
 rtl/mem_access.sv | 98 +++++++++
 tb/tb_mem_access.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared op codes, FSM states, reset/zero constants and op decode helpers for the MEM stage
package mem_access_pkg;
  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic RST_ENABLE = 1'b1;
  typedef enum logic [1:0] {MEM_IDLE, MEM_BUS, MEM_DONE} mem_state_e;
  function automatic logic is_load(input logic [7:0] op);
    return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_LW_OP;
  endfunction
  function automatic logic is_store(input logic [7:0] op);
    return op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP;
  endfunction
  function automatic logic is_byte(input logic [7:0] op);
    return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP;
  endfunction
  function automatic logic is_half(input logic [7:0] op);
    return op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP;
  endfunction
  function automatic logic is_word(input logic [7:0] op);
    return op == EXE_LW_OP || op == EXE_SW_OP;
  endfunction
endpackage

// File: rtl/mem_load_fmt.sv
// mem_load_fmt: big-endian lane select and sign/zero extension of load data (aluop, addr[1:0], data -> result)
module mem_load_fmt
  import mem_access_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic [31:0] result
);
  logic [7:0] b;
  logic [15:0] h;
  assign b = addr[1] ? (addr[0] ? data[7:0] : data[15:8]) : (addr[0] ? data[23:16] : data[31:24]);
  assign h = addr[1] ? data[15:0] : data[31:16];
  assign result = aluop == EXE_LB_OP  ? {{24{b[7]}}, b} :
                  aluop == EXE_LBU_OP ? {24'd0, b} :
                  aluop == EXE_LH_OP  ? {{16{h[15]}}, h} :
                  aluop == EXE_LHU_OP ? {16'd0, h} : data;
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM stage; pass-through of ALU results, req/ack bus FSM for loads/stores with stall; MEM_ALIGN_CHECK_EN enables misalign trap; ports: EX/MEM inputs, MEM/WB outputs, stallreq_o, bus_* master, exc_misalign_o
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [7:0]        aluop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic              flush_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stallreq_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              exc_misalign_o
);
  mem_state_e state;
  logic [DATA_W-1:0] rdata_q, load_data, wdata_next;
  logic [7:0] op_q;
  logic [1:0] lo_q;
  logic [3:0] sel_next;
  logic flushed_q, live, mem_op, misalign, start;
  assign live = rst != RST_ENABLE;
  assign mem_op = is_load(aluop_i) | is_store(aluop_i);
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = mem_op & (is_half(aluop_i) ? mem_addr_i[0] : is_word(aluop_i) & |mem_addr_i[1:0]);
`else
  assign misalign = 1'b0;
`endif
  assign start = state == MEM_IDLE & mem_op & !flush_i & !misalign;
  assign exc_misalign_o = live & state == MEM_IDLE & misalign;
  assign sel_next = is_byte(aluop_i) ? 4'b1000 >> mem_addr_i[1:0] :
                    is_half(aluop_i) ? (mem_addr_i[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign wdata_next = is_byte(aluop_i) ? {4{store_data_i[7:0]}} :
                      is_half(aluop_i) ? {2{store_data_i[15:0]}} : store_data_i;
  mem_load_fmt u_fmt (
    .aluop  (op_q),
    .addr   (lo_q),
    .data   (rdata_q),
    .result (load_data)
  );
  assign wd_o = live ? wd_i : 5'd0;
  // a flush seen while the bus was busy still lets the bus finish, but the load result is dropped
  assign wreg_o = live & !flush_i & wreg_i &
                  (state == MEM_IDLE ? !mem_op : state == MEM_DONE & is_load(op_q) & !flushed_q);
  assign wdata_o = !live ? ZERO_WORD : (state == MEM_DONE & is_load(op_q)) ? load_data : wdata_i;
  assign stallreq_o = live & (start | state == MEM_BUS);
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state       <= MEM_IDLE;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= '0;
      bus_wdata_o <= '0;
      rdata_q     <= '0;
      op_q        <= '0;
      lo_q        <= '0;
      flushed_q   <= 1'b0;
    end else begin
      case (state)
        MEM_IDLE: if (start) begin
          bus_req_o   <= 1'b1;
          bus_we_o    <= is_store(aluop_i);
          bus_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
          bus_sel_o   <= sel_next;
          bus_wdata_o <= wdata_next;
          op_q        <= aluop_i;
          lo_q        <= mem_addr_i[1:0];
          flushed_q   <= 1'b0;
          state       <= MEM_BUS;
        end
        MEM_BUS: begin
          flushed_q <= flushed_q | flush_i;
          if (bus_ack_i) begin
            rdata_q   <= bus_rdata_i;
            bus_req_o <= 1'b0;
            state     <= MEM_DONE;
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed and randomized checks of mem_access against a byte-lane arithmetic model
module tb_mem_access;
  import mem_access_pkg::*;
  logic clk, rst, wreg_i, flush_i, wreg_o, stallreq_o, bus_req_o, bus_we_o, bus_ack_i, exc_misalign_o;
  logic [4:0] wd_i, wd_o;
  logic [7:0] aluop_i;
  logic [31:0] wdata_i, mem_addr_i, store_data_i, wdata_o, bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0] bus_sel_o;
  int errors = 0, checks = 0;
  localparam logic [7:0] OR_OP = 8'h25;
  logic [7:0] ops [8] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};

  mem_access dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .store_data_i(store_data_i), .flush_i(flush_i), .wd_o(wd_o),
    .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .exc_misalign_o(exc_misalign_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [7:0] op);
    if (op == EXE_LW_OP || op == EXE_SW_OP) return 4;
    if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
    return 1;
  endfunction
  function automatic bit is_ld(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction
  // lane n (0 = most significant byte) of a big-endian word
  function automatic logic [31:0] m_sel(input logic [7:0] op, input logic [31:0] addr);
    int n = size_of(op);
    int a = int'(addr % 4);
    if (n == 4) return 32'hF;
    if (n == 2) return (a >= 2) ? 32'h3 : 32'hC;
    return 32'(1 << (3 - a));
  endfunction
  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] sd);
    int n = size_of(op);
    if (n == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction
  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rd);
    int n = size_of(op);
    int a = int'(addr % 4);
    logic [31:0] v;
    if (n == 4) return rd;
    if (n == 2) begin
      v = (rd >> ((a >= 2) ? 0 : 16)) & 32'hFFFF;
      return (op == EXE_LH_OP && v >= 32'h8000) ? v + 32'hFFFF_0000 : v;
    end
    v = (rd >> (8 * (3 - a))) & 32'hFF;
    return (op == EXE_LB_OP && v >= 32'h80) ? v + 32'hFFFF_FF00 : v;
  endfunction

  task automatic pass_op(input logic [4:0] wd, input logic wr, input logic [31:0] wdata);
    aluop_i = OR_OP; wd_i = wd; wreg_i = wr; wdata_i = wdata; flush_i = 0;
    @(negedge clk);
    chk("pass wd", 32'(wd_o), 32'(wd));
    chk("pass wreg", 32'(wreg_o), 32'(wr));
    chk("pass wdata", wdata_o, wdata);
    chk("pass stall", 32'(stallreq_o), 0);
    chk("pass req", 32'(bus_req_o), 0);
    @(posedge clk); #1;
  endtask

  task automatic mem_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rd, input int delay, input int flush_at);
    logic [4:0] wd = 5'($urandom);
    bit keep = is_ld(op) && flush_at < 0;
    aluop_i = op; wd_i = wd; wreg_i = 1; wdata_i = $urandom; mem_addr_i = addr; store_data_i = sd; flush_i = 0;
    @(negedge clk);
    chk("idle stall", 32'(stallreq_o), 1);
    chk("idle wreg", 32'(wreg_o), 0);
    chk("idle req", 32'(bus_req_o), 0);
    chk("idle exc", 32'(exc_misalign_o), 0);
    for (int k = 0; k <= delay; k++) begin
      @(posedge clk); #1;
      bus_ack_i = (k == delay);
      bus_rdata_i = (k == delay) ? rd : $urandom;
      flush_i = (k == flush_at);
      @(negedge clk);
      chk("bus req", 32'(bus_req_o), 1);
      chk("bus we", 32'(bus_we_o), 32'(!is_ld(op)));
      chk("bus addr", bus_addr_o, addr & ~32'h3);
      chk("bus sel", 32'(bus_sel_o), m_sel(op, addr));
      if (!is_ld(op)) chk("bus wdata", bus_wdata_o, m_wdata(op, sd));
      chk("bus stall", 32'(stallreq_o), 1);
      chk("bus wreg", 32'(wreg_o), 0);
    end
    @(posedge clk); #1;
    bus_ack_i = 0; flush_i = 0; bus_rdata_i = $urandom;
    @(negedge clk);
    chk("done stall", 32'(stallreq_o), 0);
    chk("done req", 32'(bus_req_o), 0);
    chk("done wreg", 32'(wreg_o), 32'(keep));
    chk("done wd", 32'(wd_o), 32'(wd));
    if (keep) chk("done wdata", wdata_o, m_load(op, addr, rd));
    @(posedge clk); #1;
    aluop_i = OR_OP;
  endtask

  initial begin
    rst = 1; flush_i = 0; bus_ack_i = 0; bus_rdata_i = 32'hDEAD_BEEF;
    wd_i = 5'd7; wreg_i = 1; wdata_i = 32'h1234_5678; aluop_i = EXE_LW_OP;
    mem_addr_i = 32'h100; store_data_i = 32'h55;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst wd", 32'(wd_o), 0);
    chk("rst wreg", 32'(wreg_o), 0);
    chk("rst wdata", wdata_o, 0);
    chk("rst stall", 32'(stallreq_o), 0);
    chk("rst req", 32'(bus_req_o), 0);
    chk("rst we", 32'(bus_we_o), 0);
    chk("rst addr", bus_addr_o, 0);
    chk("rst sel", 32'(bus_sel_o), 0);
    chk("rst bwdata", bus_wdata_o, 0);
    chk("rst exc", 32'(exc_misalign_o), 0);
    @(posedge clk); #1;
    rst = 0;
    pass_op(5'd5, 1, 32'h0000_FFFF);
    mem_op(EXE_LW_OP, 32'h100, 0, 32'h1234_5678, 1, -1);
    mem_op(EXE_LB_OP, 32'h103, 0, 32'h0000_00F0, 0, -1);
    mem_op(EXE_LBU_OP, 32'h103, 0, 32'h0000_00F0, 0, -1);
    mem_op(EXE_SH_OP, 32'h102, 32'h0000_ABCD, 0, 0, -1);
    mem_op(EXE_LH_OP, 32'h200, 0, 32'h8001_7FFF, 2, -1);
    mem_op(EXE_LW_OP, 32'h300, 0, 32'hCAFE_F00D, 3, 0);
    // flush with a memory op waiting in IDLE: nothing is issued
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h400; wreg_i = 1; flush_i = 1;
    @(negedge clk);
    chk("iflush stall", 32'(stallreq_o), 0);
    chk("iflush wreg", 32'(wreg_o), 0);
    @(posedge clk); #1;
    flush_i = 0; aluop_i = OR_OP;
    @(negedge clk);
    chk("iflush req", 32'(bus_req_o), 0);
    @(posedge clk); #1;
    // reset while the bus is busy, then a late ack
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h500;
    @(posedge clk); #1;
    aluop_i = OR_OP;
    @(negedge clk);
    chk("mid req", 32'(bus_req_o), 1);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("mid rst wreg", 32'(wreg_o), 0);
    chk("mid rst stall", 32'(stallreq_o), 0);
    @(posedge clk); #1;
    rst = 0; bus_ack_i = 1;
    @(negedge clk);
    chk("mid req drop", 32'(bus_req_o), 0);
    chk("late ack stall", 32'(stallreq_o), 0);
    @(posedge clk); #1;
    bus_ack_i = 0;
    pass_op(5'd9, 1, 32'h0BAD_F00D);
`ifdef MEM_ALIGN_CHECK_EN
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h101; wreg_i = 1;
    @(negedge clk);
    chk("mis exc", 32'(exc_misalign_o), 1);
    chk("mis stall", 32'(stallreq_o), 0);
    chk("mis wreg", 32'(wreg_o), 0);
    @(posedge clk); #1;
    aluop_i = OR_OP;
    @(negedge clk);
    chk("mis req", 32'(bus_req_o), 0);
    @(posedge clk); #1;
`else
    mem_op(EXE_LW_OP, 32'h101, 0, 32'h0102_0304, 0, -1);
    mem_op(EXE_LHU_OP, 32'h101, 0, 32'hFEDC_BA98, 1, -1);
`endif
    for (int i = 0; i < 60; i++) begin
      logic [7:0] op = ops[$urandom_range(0, 7)];
      logic [31:0] addr = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
      addr = addr & ~32'(size_of(op) - 1);
`endif
      if ($urandom_range(0, 4) == 0) pass_op(5'($urandom), 1'($urandom), $urandom);
      else mem_op(op, addr, $urandom, $urandom, $urandom_range(0, 3), ($urandom_range(0, 5) == 0) ? 0 : -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
